// File: rtl/dccm_arbiter_pkg.sv
// rtl/dccm_arbiter_pkg.sv - shared types for the DCCM arbiter
// Contents: req_id_t identifies which requester owns a DCCM access
// (shared with the AXI crossbar so both sides agree on the encoding).
package dccm_arbiter_pkg;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DMA  = 1'b1
    } req_id_t;

endpackage

// File: rtl/dccm_arbiter.sv
// rtl/dccm_arbiter.sv - single-port DCCM arbiter between CORE and DMA requesters
// Purpose: grants the DCCM to CORE by priority, forces a DMA grant after
// STARVE_MAX consecutive lost cycles, and returns a 1-cycle-latency response
// to whichever requester was accepted.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   core_req_* / dma_req_*         valid/ready request channels (we, addr, wdata, wstrb)
//   core_rsp_* / dma_rsp_*         response valid + read data (0 for write acks)
//   dccm_en/we/addr/wdata/wstrb    DCCM access strobe and muxed request fields
//   dccm_rdata                     DCCM read data, valid one cycle after a read strobe
module dccm_arbiter
    import dccm_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                core_req_valid,
    output logic                core_req_ready,
    input  logic                core_req_we,
    input  logic [ADDR_W-1:0]   core_req_addr,
    input  logic [DATA_W-1:0]   core_req_wdata,
    input  logic [DATA_W/8-1:0] core_req_wstrb,
    output logic                core_rsp_valid,
    output logic [DATA_W-1:0]   core_rsp_rdata,

    input  logic                dma_req_valid,
    output logic                dma_req_ready,
    input  logic                dma_req_we,
    input  logic [ADDR_W-1:0]   dma_req_addr,
    input  logic [DATA_W-1:0]   dma_req_wdata,
    input  logic [DATA_W/8-1:0] dma_req_wstrb,
    output logic                dma_rsp_valid,
    output logic [DATA_W-1:0]   dma_rsp_rdata,

    output logic                dccm_en,
    output logic                dccm_we,
    output logic [ADDR_W-1:0]   dccm_addr,
    output logic [DATA_W-1:0]   dccm_wdata,
    output logic [DATA_W/8-1:0] dccm_wstrb,
    input  logic [DATA_W-1:0]   dccm_rdata
);

    localparam int             STRB_W  = DATA_W / 8;
    localparam int             CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic             core_grant;
    logic             dma_grant;

    logic [CNT_W-1:0] starve_cnt_d, starve_cnt_q;
    logic             rsp_pend_d,   rsp_pend_q;
    req_id_t          rsp_id_d,     rsp_id_q;
    logic             rsp_rd_d,     rsp_rd_q;

    logic             rsp_live;

    // Grant is purely combinational so accept, DCCM strobe and ready all
    // happen in the request cycle. Nothing is granted while rst is high.
    always_comb begin
        dma_grant  = !rst && dma_req_valid &&
                     (!core_req_valid || (starve_cnt_q == CNT_MAX));
        core_grant = !rst && core_req_valid && !dma_grant;
    end

    assign core_req_ready = core_grant;
    assign dma_req_ready  = dma_grant;

    // DCCM request mux; all fields forced to zero when no access is made.
    always_comb begin
        dccm_en    = core_grant || dma_grant;
        dccm_we    = 1'b0;
        dccm_addr  = '0;
        dccm_wdata = '0;
        dccm_wstrb = '0;
        if (dma_grant) begin
            dccm_we    = dma_req_we;
            dccm_addr  = dma_req_addr;
            dccm_wdata = dma_req_wdata;
            dccm_wstrb = dma_req_wstrb;
        end else if (core_grant) begin
            dccm_we    = core_req_we;
            dccm_addr  = core_req_addr;
            dccm_wdata = core_req_wdata;
            dccm_wstrb = core_req_wstrb;
        end
    end

    // Starvation counter counts consecutive cycles DMA waited behind CORE.
    // Any cycle DMA is granted or not requesting restarts the count, so a
    // forced grant hands priority straight back to CORE.
    always_comb begin
        starve_cnt_d = '0;
        if (dma_req_valid && core_grant) begin
            if (starve_cnt_q == CNT_MAX) begin
                starve_cnt_d = starve_cnt_q;
            end else begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
        end
    end

    // One-deep response tag: who was accepted and whether it was a read.
    always_comb begin
        rsp_pend_d = core_grant || dma_grant;
        rsp_id_d   = dma_grant ? REQ_DMA : REQ_CORE;
        rsp_rd_d   = dma_grant ? !dma_req_we : !core_req_we;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
            rsp_pend_q   <= 1'b0;
            rsp_id_q     <= REQ_CORE;
            rsp_rd_q     <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rsp_pend_q   <= rsp_pend_d;
            rsp_id_q     <= rsp_id_d;
            rsp_rd_q     <= rsp_rd_d;
        end
    end

    // A response due in a cycle where rst is asserted is discarded; the
    // tag itself is cleared by the reset edge.
    assign rsp_live       = rsp_pend_q && !rst;
    assign core_rsp_valid = rsp_live && (rsp_id_q == REQ_CORE);
    assign dma_rsp_valid  = rsp_live && (rsp_id_q == REQ_DMA);
    assign core_rsp_rdata = (core_rsp_valid && rsp_rd_q) ? dccm_rdata : '0;
    assign dma_rsp_rdata  = (dma_rsp_valid  && rsp_rd_q) ? dccm_rdata : '0;

    // STRB_W documents the derived strobe width used on the ports.
    if (STRB_W * 8 != DATA_W) begin : g_bad_width
        $error("DATA_W must be a multiple of 8");
    end

endmodule

// File: tb/tb_dccm_arbiter.sv
// tb/tb_dccm_arbiter.sv - self-checking bench for dccm_arbiter
module tb_dccm_arbiter;

    localparam int ADDR_W     = 14;
    localparam int DATA_W     = 32;
    localparam int STRB_W     = DATA_W / 8;
    localparam int STARVE_MAX = 4;
    localparam int DEPTH      = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              core_req_valid, core_req_ready, core_req_we;
    logic [ADDR_W-1:0] core_req_addr;
    logic [DATA_W-1:0] core_req_wdata;
    logic [STRB_W-1:0] core_req_wstrb;
    logic              core_rsp_valid;
    logic [DATA_W-1:0] core_rsp_rdata;
    logic              dma_req_valid, dma_req_ready, dma_req_we;
    logic [ADDR_W-1:0] dma_req_addr;
    logic [DATA_W-1:0] dma_req_wdata;
    logic [STRB_W-1:0] dma_req_wstrb;
    logic              dma_rsp_valid;
    logic [DATA_W-1:0] dma_rsp_rdata;
    logic              dccm_en, dccm_we;
    logic [ADDR_W-1:0] dccm_addr;
    logic [DATA_W-1:0] dccm_wdata;
    logic [STRB_W-1:0] dccm_wstrb;
    logic [DATA_W-1:0] dccm_rdata = '0;

    always #5 clk = ~clk;

    dccm_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
        .core_req_we(core_req_we), .core_req_addr(core_req_addr),
        .core_req_wdata(core_req_wdata), .core_req_wstrb(core_req_wstrb),
        .core_rsp_valid(core_rsp_valid), .core_rsp_rdata(core_rsp_rdata),
        .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready),
        .dma_req_we(dma_req_we), .dma_req_addr(dma_req_addr),
        .dma_req_wdata(dma_req_wdata), .dma_req_wstrb(dma_req_wstrb),
        .dma_rsp_valid(dma_rsp_valid), .dma_rsp_rdata(dma_rsp_rdata),
        .dccm_en(dccm_en), .dccm_we(dccm_we), .dccm_addr(dccm_addr),
        .dccm_wdata(dccm_wdata), .dccm_wstrb(dccm_wstrb), .dccm_rdata(dccm_rdata)
    );

    // DCCM model: synchronous, write-first.
    logic [DATA_W-1:0] dccm_mem [DEPTH];
    always @(posedge clk) begin
        if (dccm_en) begin
            if (dccm_we) begin
                for (int b = 0; b < STRB_W; b++)
                    if (dccm_wstrb[b]) dccm_mem[dccm_addr][8*b +: 8] = dccm_wdata[8*b +: 8];
            end else begin
                dccm_rdata <= dccm_mem[dccm_addr];
            end
        end
    end

    // Reference model state (shadow memory, DMA wait count, expected response).
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int                waited;
    bit                exp_pend, exp_pend_dma;
    logic [DATA_W-1:0] exp_pend_data;
    bit                last_core_grant, last_dma_grant;
    int                total = 0;
    int                bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs were set at the preceding negedge.
    task automatic cycle();
        bit                eg_c, eg_d, c_rsp, d_rsp;
        logic              w_we;
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_wdata, nd;
        logic [STRB_W-1:0] w_wstrb;
        #1;
        eg_d = !rst && dma_req_valid && (!core_req_valid || waited >= STARVE_MAX);
        eg_c = !rst && core_req_valid && !eg_d;
        chk("core_ready", core_req_ready, eg_c);
        chk("dma_ready", dma_req_ready, eg_d);
        chk("dccm_en", dccm_en, eg_c | eg_d);
        w_we    = eg_d ? dma_req_we    : core_req_we;
        w_addr  = eg_d ? dma_req_addr  : core_req_addr;
        w_wdata = eg_d ? dma_req_wdata : core_req_wdata;
        w_wstrb = eg_d ? dma_req_wstrb : core_req_wstrb;
        if (eg_c || eg_d)
            chk("dccm_fields", {dccm_we, dccm_addr, dccm_wdata, dccm_wstrb},
                {w_we, w_addr, w_wdata, w_wstrb});
        else
            chk("dccm_idle", {dccm_we, dccm_addr, dccm_wdata, dccm_wstrb}, 64'd0);
        c_rsp = exp_pend && !exp_pend_dma && !rst;
        d_rsp = exp_pend && exp_pend_dma && !rst;
        chk("core_rsp_valid", core_rsp_valid, c_rsp);
        chk("dma_rsp_valid", dma_rsp_valid, d_rsp);
        chk("core_rsp_rdata", core_rsp_rdata, c_rsp ? exp_pend_data : '0);
        chk("dma_rsp_rdata", dma_rsp_rdata, d_rsp ? exp_pend_data : '0);
        nd = '0;
        if (eg_c || eg_d) begin
            if (w_we) begin
                for (int b = 0; b < STRB_W; b++)
                    if (w_wstrb[b]) ref_mem[w_addr][8*b +: 8] = w_wdata[8*b +: 8];
            end else begin
                nd = ref_mem[w_addr];
            end
        end
        if (rst)                         waited = 0;
        else if (dma_req_valid && eg_c)  waited = (waited + 1 > STARVE_MAX) ? STARVE_MAX : waited + 1;
        else                             waited = 0;
        exp_pend        = eg_c || eg_d;
        exp_pend_dma    = eg_d;
        exp_pend_data   = nd;
        last_core_grant = eg_c;
        last_dma_grant  = eg_d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_core(input bit v, input bit we, input int addr, input logic [31:0] wd,
                            input logic [3:0] st);
        core_req_valid = v; core_req_we = we; core_req_addr = ADDR_W'(addr);
        core_req_wdata = wd; core_req_wstrb = st;
    endtask

    task automatic set_dma(input bit v, input bit we, input int addr, input logic [31:0] wd,
                           input logic [3:0] st);
        dma_req_valid = v; dma_req_we = we; dma_req_addr = ADDR_W'(addr);
        dma_req_wdata = wd; dma_req_wstrb = st;
    endtask

    initial begin
        logic [DATA_W-1:0] v;
        for (int a = 0; a < DEPTH; a++) begin
            v = $urandom;
            dccm_mem[a] = v;
            ref_mem[a]  = v;
        end
        waited = 0; exp_pend = 0; exp_pend_dma = 0; exp_pend_data = '0;
        rst = 1'b1;
        set_core(1, 0, 1, 0, 0);
        set_dma(1, 0, 2, 0, 0);
        @(negedge clk);

        // 1: reset held with both valid
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t1_quiet", {core_req_ready, dma_req_ready, dccm_en, core_rsp_valid, dma_rsp_valid}, 64'd0);
            cycle();
        end
        rst = 1'b0;
        set_core(0, 0, 0, 0, 0);
        set_dma(0, 0, 0, 0, 0);
        cycle();

        // 2: lone CORE read
        dccm_mem[16'h010] = 32'hDEADBEEF; ref_mem[16'h010] = 32'hDEADBEEF;
        set_core(1, 0, 'h010, 0, 0);
        #1 chk("t2_ready", core_req_ready, 1);
        cycle();
        set_core(0, 0, 0, 0, 0);
        chk("t2_rsp_valid", core_rsp_valid, 1);
        chk("t2_rdata", core_rsp_rdata, 32'hDEADBEEF);
        chk("t2_dma_quiet", dma_rsp_valid, 0);
        cycle();

        // 3: both valid continuously -> C,C,C,C,D repeating
        for (int i = 0; i < 15; i++) begin
            set_core(1, 0, $urandom_range(0, 15), 0, 0);
            set_dma(1, 0, $urandom_range(0, 15), 0, 0);
            cycle();
            chk("t3_pattern", last_dma_grant, (i % 5) == 4);
        end
        set_core(0, 0, 0, 0, 0);
        set_dma(0, 0, 0, 0, 0);
        cycle();

        // 4: DMA partial write then CORE read same address
        dccm_mem['h020] = 32'hFFFFFFFF; ref_mem['h020] = 32'hFFFFFFFF;
        set_dma(1, 1, 'h020, 32'h12345678, 4'b0011);
        cycle();
        set_dma(0, 0, 0, 0, 0);
        set_core(1, 0, 'h020, 0, 0);
        chk("t4_dma_ack", dma_rsp_valid, 1);
        chk("t4_dma_ack_rdata", dma_rsp_rdata, 0);
        cycle();
        set_core(0, 0, 0, 0, 0);
        chk("t4_core_rdata", core_rsp_rdata, 32'hFFFF5678);
        cycle();

        // 5: CORE read in flight, rst next cycle; starvation count cleared
        for (int i = 0; i < 3; i++) begin
            set_core(1, 0, 'h030 + i, 0, 0);
            set_dma(1, 0, 'h040, 0, 0);
            cycle();
        end
        rst = 1'b1;
        #1 chk("t5_rsp_dropped", core_rsp_valid, 0);
        cycle();
        rst = 1'b0;
        #1 chk("t5_rsp_after_rst", core_rsp_valid, 0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t5_starve_cleared", last_dma_grant, i == 4);
        end
        set_core(0, 0, 0, 0, 0);
        set_dma(0, 0, 0, 0, 0);
        cycle();

        // 6: DMA drops after 2 lost cycles, then re-asserts
        set_core(1, 0, 'h050, 0, 0);
        set_dma(1, 0, 'h060, 0, 0);
        cycle();
        cycle();
        set_dma(0, 0, 0, 0, 0);
        cycle();
        set_dma(1, 0, 'h060, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t6_regrant", last_dma_grant, i == 4);
        end
        set_core(0, 0, 0, 0, 0);
        set_dma(0, 0, 0, 0, 0);
        cycle();

        // Random traffic, requesters hold fields until accepted.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            if (!(core_req_valid && !last_core_grant))
                set_core($urandom_range(0, 2) != 0, $urandom_range(0, 1),
                         ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 15)),
                         $urandom, 4'($urandom));
            if (!(dma_req_valid && !last_dma_grant))
                set_dma($urandom_range(0, 2) != 0, $urandom_range(0, 1),
                        ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 15)),
                        $urandom, 4'($urandom));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
